serial_subtractor: RTL and testbench

//  Bit-serial unsigned subtractor: diff = a - b (mod 2^WIDTH) plus a borrow-out flag.

---
 rtl/serial_arith_pkg.sv | 15 +
 rtl/full_subtractor.sv | 14 +
 rtl/serial_subtractor.sv | 99 +++++++++
 tb/tb_serial_subtractor.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic units.
// Holds the common FSM state encoding and counter sizing helper.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full-subtractor cell.
// The borrow state is held by the instantiating unit.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Start/busy/done handshake; diff/borrow held until the next result.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CW-1:0]    count;
    logic             bi;
    logic             d_bit;
    logic             bo_bit;
    logic             last_bit;
    logic             load;

    full_subtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (bi),
        .d    (d_bit),
        .bout (bo_bit)
    );

    assign last_bit = (count == CW'(WIDTH - 1));
    assign busy     = (state == S_RUN);
    assign done     = (state == S_DONE);
    // DONE already reports busy==0, so a new request is taken there too
    assign load     = start && (state != S_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (last_bit) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = start ? S_RUN : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            count  <= '0;
            bi     <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
        end else if (load) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            count  <= '0;
            bi     <= 1'b0;
        end else if (state == S_RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= {d_bit, res_sr[WIDTH-1:1]};
            bi     <= bo_bit;
            count  <= count + CW'(1);
            if (last_bit) begin
                diff   <= {d_bit, res_sr[WIDTH-1:1]};
                borrow <= bo_bit;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
// Each scenario task drives its stimulus and checks results inline.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow;

    int n_checks = 0;
    int n_fail   = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launches one op and waits for done; observations only, no checks.
    task automatic do_op(input logic [7:0] xa, input logic [7:0] xb,
                         output int cyc, output logic [7:0] d,
                         output logic bo);
        @(negedge clk);
        a = xa;
        b = xb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        d  = diff;
        bo = borrow;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, diff, borrow} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 0",
                     {busy, done, diff, borrow});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idle: busy/done %b required 00", {busy, done});
        end
    endtask

    task automatic test_basic();
        int cyc;
        logic [7:0] d;
        logic bo;
        do_op(8'h05, 8'h03, cyc, d, bo);
        n_checks++;
        if (cyc !== 8) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d required 8", cyc);
        end
        n_checks++;
        if (d !== 8'h02 || bo !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: got %h/%b required 02/0", d, bo);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_pulse: done=%b busy=%b required 0/0",
                     done, busy);
        end
    endtask

    task automatic test_borrow();
        logic [7:0] va [2] = '{8'h03, 8'h00};
        logic [7:0] vb [2] = '{8'h05, 8'h01};
        int cyc;
        logic [7:0] d;
        logic bo;
        for (int i = 0; i < 2; i++) begin
            do_op(va[i], vb[i], cyc, d, bo);
            n_checks++;
            if (d !== 8'(va[i] - vb[i]) || bo !== 1'b1 || cyc !== 8) begin
                n_fail++;
                $display("FAIL borrow_%0d: got %h/%b in %0d required %h/1 in 8",
                         i, d, bo, cyc, 8'(va[i] - vb[i]));
            end
        end
    endtask

    task automatic test_edges();
        logic [7:0] va [3] = '{8'hA5, 8'hFF, 8'h00};
        logic [7:0] vb [3] = '{8'hA5, 8'h00, 8'h00};
        logic [7:0] ed [3] = '{8'h00, 8'hFF, 8'h00};
        int cyc;
        logic [7:0] d;
        logic bo;
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], cyc, d, bo);
            n_checks++;
            if (d !== ed[i] || d !== 8'(va[i] - vb[i]) || bo !== 1'b0) begin
                n_fail++;
                $display("FAIL edge_%0d: got %h/%b required %h/0",
                         i, d, bo, ed[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int ndone = 0;
        int first = -1;
        logic prev = 1'b0;
        logic [7:0] d = 8'h00;
        logic bo = 1'b0;
        @(negedge clk);
        a = 8'h05;
        b = 8'h03;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 3) begin
                start = 1'b1;
                a = 8'h10;
                b = 8'h01;
            end else if (i == 4) begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done === 1'b1) begin
                n_checks++;
                if (prev) begin
                    n_fail++;
                    $display("FAIL ignore_done_twice: done high at %0d and %0d",
                             i - 1, i);
                end
                ndone++;
                if (first < 0) begin
                    first = i;
                    d = diff;
                    bo = borrow;
                end
            end
            prev = done;
        end
        n_checks++;
        if (ndone !== 1 || first !== 8) begin
            n_fail++;
            $display("FAIL ignore_done_count: got %0d at %0d required 1 at 8",
                     ndone, first);
        end
        n_checks++;
        if (d !== 8'h02 || bo !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_result: got %h/%b required 02/0", d, bo);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        logic [7:0] d;
        logic bo;
        @(negedge clk);
        a = 8'h55;
        b = 8'h11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || diff !== 8'h02) begin
            n_fail++;
            $display("FAIL midrun_pre: busy=%b diff=%h required 1/02", busy, diff);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, diff, borrow} !== 11'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: got %b required 0",
                     {busy, done, diff, borrow});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL midrun_no_done: done=%b required 0", done);
            end
        end
        do_op(8'h80, 8'h7F, cyc, d, bo);
        n_checks++;
        if (d !== 8'h01 || bo !== 1'b0 || cyc !== 8) begin
            n_fail++;
            $display("FAIL midrun_after: got %h/%b in %0d required 01/0 in 8",
                     d, bo, cyc);
        end
    endtask

    task automatic test_back_to_back();
        int cyc = 0;
        @(negedge clk);
        a = 8'h09;
        b = 8'h04;
        start = 1'b1;
        @(negedge clk);
        a = 8'h04;
        b = 8'h09;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc !== 8 || diff !== 8'h05 || borrow !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: got %h/%b in %0d required 05/0 in 8",
                     diff, borrow, cyc);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_restart: done=%b busy=%b required 0/1", done, busy);
        end
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            n_checks++;
            if (diff !== 8'h05) begin
                n_fail++;
                $display("FAIL b2b_hold: diff=%h required 05", diff);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        n_checks++;
        if (cyc !== 9) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d required 9", cyc);
        end
        n_checks++;
        if (diff !== 8'(8'h04 - 8'h09) || borrow !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: got %h/%b required fb/1", diff, borrow);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: done=%b busy=%b required 0/0", done, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_edges();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
